// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 multiplier.
// Operand classes, flag bit positions, bias and canonical qNaN.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // Positions within the 4-bit flag word {invalid, overflow, underflow, inexact}
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1 followed by zeros}, right-aligned in 64 bits
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign, exponent, significand (hidden bit) and class.
// Ports: op_i operand; sign_o, exp_o, sig_o, cls_o. Subnormals read as zero.
module fp_unpack import fp_mul_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output fp_class_e            cls_o
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;

  assign sign_o = op_i[EXP_W+MAN_W];
  assign e      = op_i[EXP_W+MAN_W-1:MAN_W];
  assign f      = op_i[MAN_W-1:0];

  always_comb begin
    cls_o = NORM;
    exp_o = e;
    sig_o = {1'b1, f};
    if (e == '0) begin
      // flush-to-zero covers true zero and subnormal alike
      cls_o = ZERO;
      exp_o = '0;
      sig_o = '0;
    end else if (&e) begin
      if (f == '0)
        cls_o = INF;
      else if (f[MAN_W-1])
        cls_o = QNAN;
      else
        cls_o = SNAN;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE-754 multiplier, FTZ, valid/ready with global advance enable.
// Ports: clk, rst, in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_result/out_flags.
// FP_MUL_RNE_EN: defined -> round-nearest-even; undefined -> truncate, saturate.
module fp_mul_pipe import fp_mul_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [3:0]           out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;

  localparam logic [EW-1:0] BIAS_C = EW'(fp_bias(EXP_W));
  localparam logic [W-1:0]  QNAN_C = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX_C  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO_C = '0;

  logic adv;

  // ---------------- S1: unpack, classify, exponent sum
  logic             ua_s, ub_s;
  logic [EXP_W-1:0] ua_e, ub_e;
  logic [MAN_W:0]   ua_m, ub_m;
  fp_class_e        ca, cb;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_a (
    .op_i  (in_a),
    .sign_o(ua_s),
    .exp_o (ua_e),
    .sig_o (ua_m),
    .cls_o (ca)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_b (
    .op_i  (in_b),
    .sign_o(ub_s),
    .exp_o (ub_e),
    .sig_o (ub_m),
    .cls_o (cb)
  );

  logic                 s1_sign_d, s1_spec_d;
  logic [W-1:0]         s1_res_d;
  logic [3:0]           s1_flg_d;
  logic signed [EW-1:0] s1_exp_d;

  logic                 v1_q, s1_sign_q, s1_spec_q;
  logic [W-1:0]         s1_res_q;
  logic [3:0]           s1_flg_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [MAN_W:0]       s1_sa_q, s1_sb_q;

  logic a_nan, b_nan, a_snan, b_snan;

  assign a_nan  = (ca == QNAN) || (ca == SNAN);
  assign b_nan  = (cb == QNAN) || (cb == SNAN);
  assign a_snan = (ca == SNAN);
  assign b_snan = (cb == SNAN);

  // Special results resolve here and ride the pipe beside the datapath
  always_comb begin
    s1_sign_d = ua_s ^ ub_s;
    s1_spec_d = 1'b1;
    s1_res_d  = QNAN_C;
    s1_flg_d  = '0;
    if (a_nan || b_nan) begin
      s1_flg_d[FLAG_NV] = a_snan || b_snan;
    end else if ((ca == INF && cb == ZERO) ||
                 (ca == ZERO && cb == INF)) begin
      s1_flg_d[FLAG_NV] = 1'b1;
    end else if (ca == INF || cb == INF) begin
      s1_res_d = {s1_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == ZERO || cb == ZERO) begin
      s1_res_d = {s1_sign_d, {(W-1){1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
    end
    s1_exp_d = EW'(ua_e) + EW'(ub_e) - BIAS_C;
  end

  // ---------------- S2: significand product
  logic [PW-1:0] s2_prod_d;

  logic                 v2_q, s2_sign_q, s2_spec_q;
  logic [W-1:0]         s2_res_q;
  logic [3:0]           s2_flg_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [PW-1:0]        s2_prod_q;

  assign s2_prod_d = PW'(s1_sa_q) * PW'(s1_sb_q);

  // ---------------- S3: normalise, round, pack, flags
  logic [PW-1:0]        norm;
  logic                 unused_hid;
  logic signed [EW-1:0] e_n, e_r;
  logic [MAN_W-1:0]     frac, fr;
  logic                 g, rb, st, nx;
  logic [W-1:0]         res_d;
  logic [3:0]           flg_d;

`ifdef FP_MUL_RNE_EN
  logic           up;
  logic [MAN_W:0] rnd;
`endif

  assign unused_hid = norm[PW-1];

  always_comb begin
    // product lies in [1,4): align so the hidden bit sits at the top
    norm = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
    e_n  = s2_exp_q + EW'(s2_prod_q[PW-1]);
    frac = norm[PW-2:MAN_W+1];
    g    = norm[MAN_W];
    rb   = norm[MAN_W-1];
    st   = |norm[MAN_W-2:0];
    nx   = g | rb | st;
`ifdef FP_MUL_RNE_EN
    up  = g & (rb | st | frac[0]);
    rnd = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    // carry-out leaves rnd[MAN_W-1:0] all zero, i.e. fraction 0
    fr  = rnd[MAN_W-1:0];
    e_r = e_n + EW'(rnd[MAN_W]);
`else
    fr  = frac;
    e_r = e_n;
`endif
    res_d = {s2_sign_q, e_r[EXP_W-1:0], fr};
    flg_d = '0;
    flg_d[FLAG_NX] = nx;
    if (s2_spec_q) begin
      res_d = s2_res_q;
      flg_d = s2_flg_q;
    end else if (e_r >= EMAX_C) begin
`ifdef FP_MUL_RNE_EN
      res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      res_d = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
      flg_d = '0;
      flg_d[FLAG_OF] = 1'b1;
      flg_d[FLAG_NX] = 1'b1;
    end else if (e_r <= EZERO_C) begin
      res_d = {s2_sign_q, {(W-1){1'b0}}};
      flg_d = '0;
      flg_d[FLAG_UF] = 1'b1;
      flg_d[FLAG_NX] = 1'b1;
    end
  end

  // ---------------- handshake and registers
  logic         ov_q;
  logic [W-1:0] res_q;
  logic [3:0]   flg_q;

  assign adv        = !ov_q || out_ready;
  assign in_ready   = adv;
  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_res_q  <= '0;
      s1_flg_q  <= '0;
      s1_exp_q  <= '0;
      s1_sa_q   <= '0;
      s1_sb_q   <= '0;
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_res_q  <= '0;
      s2_flg_q  <= '0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      ov_q      <= 1'b0;
      res_q     <= '0;
      flg_q     <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      s1_sign_q <= s1_sign_d;
      s1_spec_q <= s1_spec_d;
      s1_res_q  <= s1_res_d;
      s1_flg_q  <= s1_flg_d;
      s1_exp_q  <= s1_exp_d;
      s1_sa_q   <= ua_m;
      s1_sb_q   <= ub_m;
      v2_q      <= v1_q;
      s2_sign_q <= s1_sign_q;
      s2_spec_q <= s1_spec_q;
      s2_res_q  <= s1_res_q;
      s2_flg_q  <= s1_flg_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      ov_q      <= v2_q;
      res_q     <= res_d;
      flg_q     <= flg_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (binary32 defaults).
// Vector table, stall/reset sequences and random ops against an arithmetic model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit acc;
  bit saw_block;
  bit prev_stall = 0;
  logic [31:0] prev_res;
  logic [3:0]  prev_flg;
  logic [31:0] cur_res;
  logic [3:0]  cur_flg;
  bit          cur_lat;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Model: exact integer product of significands, rounded by remainder size
  function automatic logic [35:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    int e;
    int sh;
    logic s;
    bit na, nb, sa, sbn, ia, ib, za, zb;
    longint unsigned p, q, rem, half;
    logic [3:0] f;
    s   = a[31] ^ b[31];
    na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sa  = na && !a[22];
    sbn = nb && !b[22];
    ia  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    za  = (a[30:23] == 8'h00);
    zb  = (b[30:23] == 8'h00);
    if (na || nb) return {(sa || sbn) ? 4'b1000 : 4'b0000, 32'h7FC00000};
    if ((ia && zb) || (za && ib)) return {4'b1000, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
    if (za || zb) return {4'b0000, s, 31'd0};
    p  = ({41'd1, a[22:0]}) * ({41'd1, b[22:0]});
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    f    = (rem != 0) ? 4'b0001 : 4'b0000;
`ifdef FP_MUL_RNE_EN
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
`endif
    if (e >= 255) begin
`ifdef FP_MUL_RNE_EN
      return {4'b0101, s, 8'hFF, 23'd0};
`else
      return {4'b0101, s, 31'h7F7FFFFF};
`endif
    end
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {f, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: r[30:0] = {8'hFF, 23'd0};
      2: r[30:22] = 9'h1FF;
      3: begin
        r[30:22] = {8'hFF, 1'b0};
        r[0] = 1'b1;
      end
      4: r[30:23] = 8'h00;
      5, 6: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // Callers drive inputs just after a falling edge; handshakes are
  // evaluated 1ns later, well before the next rising edge.
  task automatic tick();
    exp_t e;
    #1;
    acc = 1'b0;
    if (!rst) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, prev_res);
        chk("hold_flags", out_flags, prev_flg);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("flags", out_flags, e.flg);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        e.res = cur_res;
        e.flg = cur_flg;
        e.cyc = cyc;
        e.lat = cur_lat;
        sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_flg   = out_flags;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  vec_t vt[$];

  initial begin
    logic [35:0] m;
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    cur_res   = '0;
    cur_flg   = '0;
    cur_lat   = 1'b0;
    saw_block = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    vt.push_back('{32'h42FA0000, 32'h41410000, 32'h44BC7A00, 4'b0000});
    vt.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
    vt.push_back('{32'h7F800000, 32'hBFC00000, 32'hFF800000, 4'b0000});
`ifdef FP_MUL_RNE_EN
    vt.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101});
    vt.push_back('{32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001});
`else
    vt.push_back('{32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 4'b0101});
    vt.push_back('{32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0001});
`endif
    vt.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011});
    vt.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
    vt.push_back('{32'h7FC00000, 32'h7F800000, 32'h7FC00000, 4'b0000});
    vt.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000});
    vt.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000});
    vt.push_back('{32'h80000001, 32'h3F800000, 32'h80000000, 4'b0000});
    vt.push_back('{32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000});

    // table vectors back-to-back, latency checked
    for (int i = 0; i < vt.size(); i++) begin
      in_valid = 1'b1;
      in_a     = vt[i].a;
      in_b     = vt[i].b;
      cur_res  = vt[i].res;
      cur_flg  = vt[i].flg;
      cur_lat  = 1'b1;
      tick();
    end
    drain();

    // 8-op stream, consumer blocked for cycles 4..8
    k = 0;
    saw_block = 1'b0;
    cur_lat = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      if (k < 8) begin
        in_valid = 1'b1;
        in_a = 32'h3F800000 + 32'(k << 20);
        in_b = 32'h40000000 + 32'(k);
        m = ref_mul(in_a, in_b);
        {cur_flg, cur_res} = m;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (acc) k++;
    end
    chk("stream_issued", k, 8);
    chk("stream_in_ready_drop", saw_block, 1);
    drain();

    // reset with two operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 32'h40400000;
      in_b = 32'h40A00000;
      cur_res = 32'h41700000;
      cur_flg = 4'b0000;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_flight_valid", out_valid, 0);
    sb.delete();
    prev_stall = 1'b0;
    tick();
    chk("rst_flight_valid2", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("rst_flight_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_ghost", out_valid, 0);
    end

    // randomised traffic with random backpressure
    k = 0;
    for (int c = 0; c < 3000 && k < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_a = rand_op();
      in_b = rand_op();
      m = ref_mul(in_a, in_b);
      {cur_flg, cur_res} = m;
      tick();
      if (acc) k++;
    end
    chk("random_issued", k, 400);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
